// File: rtl/audio_sdr_sched.sv
// rtl/audio_sdr_sched.sv - SDRAM burst scheduler for audio record/playback (optional residual flush: AUDIO_SCHED_FLUSH_EN)
module audio_sdr_sched #(
    parameter int                BURST_LEN = 256,
    parameter int                ADDR_W    = 24,
    parameter logic [ADDR_W-1:0] MAX_ADDR  = 24'hFFFF00
) (
    input  logic              clk50M,
    input  logic              reset_n,
    input  logic              record_en,
    input  logic              play_en,
    input  logic              sdr_waddr_set,
    input  logic              sdr_raddr_set,
    input  logic [9:0]        wr_fifo_level,
    input  logic [9:0]        rd_fifo_level,
    output logic              cmd_req,
    output logic              cmd_wr,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [8:0]        cmd_len,
    input  logic              cmd_ack,
    input  logic              burst_done,
    output logic              rec_full,
    output logic              play_done
);

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_REQ, S_BUSY} state_t;

    localparam logic [10:0]       FIFO_DEPTH = 11'd1024;
    localparam logic [10:0]       BURST_11   = 11'(BURST_LEN);
    localparam logic [8:0]        BURST_L9   = 9'(BURST_LEN);
    localparam logic [ADDR_W-1:0] BURST_A    = ADDR_W'(BURST_LEN);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] waddr, raddr, end_addr;
    logic              last_wr;
    logic              record_en_d;
    logic              rec_fall;
    logic              wr_elig, rd_elig;
    logic              grant_wr, grant_rd;
    logic [8:0]        grant_len;
    logic              wr_done, rd_done;
    logic [ADDR_W:0]   waddr_adv;
    logic              waddr_ovf;
    logic [ADDR_W-1:0] raddr_nx;

    assign rec_fall  = record_en_d & ~record_en;
    assign wr_done   = (state == S_BUSY) && burst_done && cmd_wr;
    assign rd_done   = (state == S_BUSY) && burst_done && !cmd_wr;
    // cmd_len holds the length of the burst in flight, so flush bursts advance by their own size
    assign waddr_adv = {1'b0, waddr} + {{(ADDR_W-8){1'b0}}, cmd_len};
    assign waddr_ovf = waddr_adv > {1'b0, MAX_ADDR};

    assign wr_elig = record_en && ({1'b0, wr_fifo_level} >= BURST_11) && !rec_full && !sdr_waddr_set;
    assign rd_elig = play_en && ((FIFO_DEPTH - {1'b0, rd_fifo_level}) >= BURST_11)
                     && (raddr != end_addr) && !sdr_raddr_set;

`ifdef AUDIO_SCHED_FLUSH_EN
    logic       flush_pend, cur_flush, fl_elig, grant_flush, flush_start;
    logic [8:0] flush_len;

    assign flush_start = (wr_fifo_level != 10'd0) && !rec_full;
    assign fl_elig     = flush_pend && !rec_full && !sdr_waddr_set;
    assign grant_len   = grant_flush ? flush_len : BURST_L9;
    // a residual end_addr need not be burst aligned, so the last read stops exactly on it
    assign raddr_nx    = ((end_addr > raddr) && ((end_addr - raddr) < BURST_A)) ? end_addr : raddr + BURST_A;

    // capture the residual record length on the falling edge and hold the request until granted
    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            flush_pend <= 1'b0;
            flush_len  <= 9'd0;
            cur_flush  <= 1'b0;
        end else begin
            if (rec_fall && flush_start) begin
                flush_pend <= 1'b1;
                flush_len  <= (wr_fifo_level > 10'(BURST_LEN)) ? BURST_L9 : wr_fifo_level[8:0];
            end else if (grant_flush || (flush_pend && rec_full)) begin
                flush_pend <= 1'b0;
            end
            if (grant_wr || grant_rd)
                cur_flush <= grant_flush;
        end
    end
`else
    assign grant_len = BURST_L9;
    assign raddr_nx  = raddr + BURST_A;
`endif

    // state register
    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nx;
    end

    // arbitration and next-state: a pending flush beats everything, otherwise alternate on contention
    always_comb begin
        state_nx = state;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
`ifdef AUDIO_SCHED_FLUSH_EN
        grant_flush = 1'b0;
`endif
        case (state)
            S_IDLE: state_nx = S_ARB;
            S_ARB: begin
`ifdef AUDIO_SCHED_FLUSH_EN
                if (fl_elig) begin
                    grant_wr    = 1'b1;
                    grant_flush = 1'b1;
                end else
`endif
                if (wr_elig && rd_elig) begin
                    if (last_wr) grant_rd = 1'b1;
                    else         grant_wr = 1'b1;
                end else if (wr_elig) begin
                    grant_wr = 1'b1;
                end else if (rd_elig) begin
                    grant_rd = 1'b1;
                end
                if (grant_wr || grant_rd) state_nx = S_REQ;
            end
            S_REQ:   if (cmd_ack)    state_nx = S_BUSY;
            S_BUSY:  if (burst_done) state_nx = S_ARB;
            default: state_nx = S_IDLE;
        endcase
    end

    // command registers: loaded on grant, request held until acknowledged
    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            cmd_req  <= 1'b0;
            cmd_wr   <= 1'b0;
            cmd_addr <= '0;
            cmd_len  <= 9'd0;
            last_wr  <= 1'b0;
        end else if (grant_wr || grant_rd) begin
            cmd_req  <= 1'b1;
            cmd_wr   <= grant_wr;
            cmd_addr <= grant_wr ? waddr : raddr;
            cmd_len  <= grant_len;
            last_wr  <= grant_wr;
        end else if ((state == S_REQ) && cmd_ack) begin
            cmd_req  <= 1'b0;
        end
    end

    // write address and full flag; the clear wins over a coincident completion
    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            waddr    <= '0;
            rec_full <= 1'b0;
        end else if (sdr_waddr_set) begin
            waddr    <= '0;
            rec_full <= 1'b0;
        end else if (wr_done) begin
            if (waddr_ovf) rec_full <= 1'b1;
            else           waddr    <= waddr_adv[ADDR_W-1:0];
        end
    end

    // read address and playback-complete flag
    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            raddr     <= '0;
            play_done <= 1'b0;
        end else if (sdr_raddr_set) begin
            raddr     <= '0;
            play_done <= 1'b0;
        end else begin
            if (rd_done)
                raddr <= raddr_nx;
            if (play_en && (raddr == end_addr))
                play_done <= 1'b1;
        end
    end

    // end of recording: latched when record_en drops, or after the residual flush lands
    always_ff @(posedge clk50M or negedge reset_n) begin
        if (!reset_n) begin
            record_en_d <= 1'b0;
            end_addr    <= '0;
        end else begin
            record_en_d <= record_en;
`ifdef AUDIO_SCHED_FLUSH_EN
            if (rec_fall && !flush_start)
                end_addr <= waddr;
            else if (wr_done && cur_flush && !sdr_waddr_set)
                end_addr <= waddr_ovf ? waddr : waddr_adv[ADDR_W-1:0];
            else if (flush_pend && rec_full)
                end_addr <= waddr;
`else
            if (rec_fall)
                end_addr <= waddr;
`endif
        end
    end

endmodule

// File: tb/tb_audio_sdr_sched.sv
// tb/tb_audio_sdr_sched.sv - directed self-checking bench for audio_sdr_sched
module tb_audio_sdr_sched;

    logic        clk50M = 1'b0;
    logic        reset_n, record_en, play_en, sdr_waddr_set, sdr_raddr_set, cmd_ack, burst_done;
    logic [9:0]  wr_fifo_level, rd_fifo_level;
    logic        cmd_req, cmd_wr, rec_full, play_done;
    logic [23:0] cmd_addr;
    logic [8:0]  cmd_len;
    int          n_checks = 0;
    int          n_pass   = 0;

    always #10 clk50M = ~clk50M;

    audio_sdr_sched #(.BURST_LEN(256), .ADDR_W(24), .MAX_ADDR(24'h000300)) dut (
        .clk50M        (clk50M),
        .reset_n       (reset_n),
        .record_en     (record_en),
        .play_en       (play_en),
        .sdr_waddr_set (sdr_waddr_set),
        .sdr_raddr_set (sdr_raddr_set),
        .wr_fifo_level (wr_fifo_level),
        .rd_fifo_level (rd_fifo_level),
        .cmd_req       (cmd_req),
        .cmd_wr        (cmd_wr),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_ack       (cmd_ack),
        .burst_done    (burst_done),
        .rec_full      (rec_full),
        .play_done     (play_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk50M);
    endtask

    task automatic do_burst(input string tag, input logic exp_wr, input logic [23:0] exp_addr,
                            input logic [8:0] exp_len, input int ack_dly, input int done_dly,
                            input logic set_w);
        int t = 0;
        while (cmd_req !== 1'b1 && t < 50) begin
            tick(1);
            t++;
        end
        check({tag, "_req"},  32'(cmd_req), 1);
        check({tag, "_wr"},   32'(cmd_wr), 32'(exp_wr));
        check({tag, "_addr"}, 32'(cmd_addr), 32'(exp_addr));
        check({tag, "_len"},  32'(cmd_len), 32'(exp_len));
        tick(ack_dly);
        check({tag, "_hold"}, 32'({cmd_req, cmd_addr}), 32'({1'b1, exp_addr}));
        cmd_ack = 1'b1;
        tick(1);
        cmd_ack = 1'b0;
        check({tag, "_drop"}, 32'(cmd_req), 0);
        tick(done_dly - 1);
        burst_done    = 1'b1;
        sdr_waddr_set = set_w;
        tick(1);
        burst_done    = 1'b0;
        sdr_waddr_set = 1'b0;
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int seen = 0;
        repeat (n) begin
            tick(1);
            if (cmd_req) seen++;
        end
        check(tag, 32'(seen), 0);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        reset_n = 1'b0; record_en = 1'b0; play_en = 1'b0;
        sdr_waddr_set = 1'b0; sdr_raddr_set = 1'b0; cmd_ack = 1'b0; burst_done = 1'b0;
        wr_fifo_level = 10'd0; rd_fifo_level = 10'd0;
        tick(3);
        check("rst_cmd_req",  32'(cmd_req), 0);
        check("rst_cmd_wr",   32'(cmd_wr), 0);
        check("rst_cmd_addr", 32'(cmd_addr), 0);
        check("rst_cmd_len",  32'(cmd_len), 0);
        check("rst_rec_full", 32'(rec_full), 0);
        check("rst_play_done", 32'(play_done), 0);
        check("rst_state",    32'(dut.state), 0);
        check("rst_end_addr", 32'(dut.end_addr), 0);
        check("rst_last_wr",  32'(dut.last_wr), 0);

        // single write burst from address 0
        reset_n = 1'b1; record_en = 1'b1; wr_fifo_level = 10'd256;
        do_burst("w0", 1'b1, 24'd0, 9'd256, 2, 10, 1'b0);
        wr_fifo_level = 10'd0;
        check("waddr_after_w0", 32'(dut.waddr), 256);

        // completion pulse outside BUSY is ignored
        tick(2);
        burst_done = 1'b1; tick(1); burst_done = 1'b0; tick(1);
        check("stray_done", 32'(dut.waddr), 256);

        // second record burst, then stop recording
        wr_fifo_level = 10'd256;
        do_burst("w1", 1'b1, 24'd256, 9'd256, 1, 3, 1'b0);
        wr_fifo_level = 10'd0;
        record_en = 1'b0;
        tick(2);
        check("end_addr_512", 32'(dut.end_addr), 512);

        // lone read so the last grant is a read, then rewind both pointers
        play_en = 1'b1;
        do_burst("r0", 1'b0, 24'd0, 9'd256, 1, 3, 1'b0);
        play_en = 1'b0;
        check("raddr_256", 32'(dut.raddr), 256);
        sdr_waddr_set = 1'b1; sdr_raddr_set = 1'b1; tick(1);
        sdr_waddr_set = 1'b0; sdr_raddr_set = 1'b0;
        check("waddr_clr", 32'(dut.waddr), 0);
        check("raddr_clr", 32'(dut.raddr), 0);

        // contention alternates W,R,W,R
        record_en = 1'b1; wr_fifo_level = 10'd256; play_en = 1'b1;
        do_burst("c0", 1'b1, 24'd0,   9'd256, 1, 3, 1'b0);
        do_burst("c1", 1'b0, 24'd0,   9'd256, 1, 3, 1'b0);
        do_burst("c2", 1'b1, 24'd256, 9'd256, 1, 3, 1'b0);
        do_burst("c3", 1'b0, 24'd256, 9'd256, 1, 3, 1'b0);
        wr_fifo_level = 10'd0; play_en = 1'b0;
        check("c_waddr", 32'(dut.waddr), 512);
        check("c_raddr", 32'(dut.raddr), 512);

        // address clear coincident with write completion wins
        wr_fifo_level = 10'd256;
        do_burst("wset", 1'b1, 24'd512, 9'd256, 1, 3, 1'b1);
        wr_fifo_level = 10'd0;
        check("wset_waddr", 32'(dut.waddr), 0);
        check("wset_rec_full", 32'(rec_full), 0);

        // fill to MAX_ADDR (0x300): last burst holds address and sets rec_full
        wr_fifo_level = 10'd256;
        for (int i = 0; i < 4; i++)
            do_burst($sformatf("f%0d", i), 1'b1, 24'(i * 256), 9'd256, 1, 2, 1'b0);
        check("full_waddr", 32'(dut.waddr), 768);
        check("full_flag", 32'(rec_full), 1);
        expect_quiet("no_wr_after_full", 20);
        wr_fifo_level = 10'd0;

        // record 3 bursts then play them back exactly
        sdr_waddr_set = 1'b1; sdr_raddr_set = 1'b1; tick(1);
        sdr_waddr_set = 1'b0; sdr_raddr_set = 1'b0;
        check("rf_cleared", 32'(rec_full), 0);
        wr_fifo_level = 10'd256;
        for (int i = 0; i < 3; i++)
            do_burst($sformatf("p_w%0d", i), 1'b1, 24'(i * 256), 9'd256, 1, 2, 1'b0);
        wr_fifo_level = 10'd0;
        record_en = 1'b0;
        tick(2);
        check("end_addr_768", 32'(dut.end_addr), 768);
        check("play_done_pre", 32'(play_done), 0);
        play_en = 1'b1;
        for (int i = 0; i < 3; i++)
            do_burst($sformatf("p_r%0d", i), 1'b0, 24'(i * 256), 9'd256, 1, 2, 1'b0);
        expect_quiet("no_4th_read", 20);
        check("play_done_set", 32'(play_done), 1);

        // reset mid-burst aborts; late completion ignored
        play_en = 1'b0;
        record_en = 1'b1; wr_fifo_level = 10'd256;
        t = 0;
        while (cmd_req !== 1'b1 && t < 50) begin
            tick(1);
            t++;
        end
        check("mid_req", 32'(cmd_req), 1);
        cmd_ack = 1'b1; tick(1); cmd_ack = 1'b0; tick(2);
        reset_n = 1'b0; record_en = 1'b0; wr_fifo_level = 10'd0;
        tick(1);
        check("mid_rst_req", 32'(cmd_req), 0);
        check("mid_rst_state", 32'(dut.state), 0);
        reset_n = 1'b1;
        tick(2);
        burst_done = 1'b1; tick(1); burst_done = 1'b0; tick(1);
        check("late_done_waddr", 32'(dut.waddr), 0);
        check("late_done_state", 32'(dut.state), 1);

`ifdef AUDIO_SCHED_FLUSH_EN
        // residual words flushed as one short write on record_en fall
        record_en = 1'b1; wr_fifo_level = 10'd100; tick(3);
        record_en = 1'b0;
        do_burst("flush", 1'b1, 24'd0, 9'd100, 1, 3, 1'b0);
        wr_fifo_level = 10'd0;
        tick(1);
        check("flush_waddr", 32'(dut.waddr), 100);
        check("flush_end_addr", 32'(dut.end_addr), 100);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
